// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register word, register index, load funct3 encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef struct packed {
        regbits_t rd;
        word_t    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue: DEPTH-entry FIFO, head visible combinationally, one push and one pop per cycle.
// Push when full and pop when empty are ignored; the caller gates them with full/empty.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                         clk,
    input  logic                         nRST,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_dat,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head_dat,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: formats loads, arbitrates load over ALU into a queue, writes one reg/cycle.
// Latency 1 from push to reg_write; readiness depends only on the registered queue count.
module writeback_unit
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic        ld_ready,
    output logic        reg_write,
    output logic [4:0]  write_index,
    output logic [31:0] write_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy,
    output logic        ld_err
);
    localparam int CW = $clog2(DEPTH+1);

    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    wb_entry_t       w_head;
    wb_entry_t       w_push_dat;
    logic            w_push;
    logic            w_ld_fire;
    logic            w_alu_fire;
    logic            w_ld_illegal;
    logic            w_ld_drop;
    word_t           w_ld_data;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_busy_nxt;
    logic [31:0]     r_busy;
    logic            r_ld_err;

    assign ld_ready   = ~w_full;
    assign alu_ready  = ~w_full & ~ld_valid;
    assign w_ld_fire  = ld_valid & ld_ready;
    assign w_alu_fire = alu_valid & alu_ready;

    assign w_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    assign w_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    always_comb begin
        w_ld_data    = '0;
        w_ld_illegal = 1'b0;
        case (ld_funct3)
            LB:      w_ld_data = {{24{w_byte[7]}}, w_byte};
            LH: begin
                w_ld_data    = {{16{w_half[15]}}, w_half};
                w_ld_illegal = ld_addr_lo[0];
            end
            LW: begin
                w_ld_data    = ld_rdata;
                w_ld_illegal = (ld_addr_lo != 2'b00);
            end
            LBU:     w_ld_data = {24'h0, w_byte};
            LHU: begin
                w_ld_data    = {16'h0, w_half};
                w_ld_illegal = ld_addr_lo[0];
            end
            default: w_ld_illegal = 1'b1;
        endcase
    end

    // Writes to x0 complete the handshake but never occupy a queue slot.
    assign w_ld_drop       = w_ld_fire & w_ld_illegal;
    assign w_push          = (w_ld_fire & ~w_ld_illegal & (ld_rd != '0))
                           | (w_alu_fire & (alu_rd != '0));
    assign w_push_dat.rd   = w_ld_fire ? regbits_t'(ld_rd) : regbits_t'(alu_rd);
    assign w_push_dat.data = w_ld_fire ? w_ld_data : word_t'(alu_data);

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk        (clk),
        .nRST       (nRST),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (reg_write),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign reg_write   = (w_count != '0);
    assign write_index = w_empty ? 5'd0  : w_head.rd;
    assign write_data  = w_empty ? 32'd0 : w_head.data;

    // Clears are applied first so a same-cycle issue to the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (reg_write) w_busy_nxt[write_index] = 1'b0;
        if (w_ld_drop) w_busy_nxt[ld_rd] = 1'b0;
        if (issue_valid && issue_rd != '0) w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_busy   <= '0;
            r_ld_err <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_ld_err <= w_ld_drop;
        end
    end

    assign busy   = r_busy;
    assign ld_err = r_ld_err;

endmodule
